// File: rtl/comparator_2bit_if.sv
// -----------------------------------------------------------------------------
// comparator_2bit_if
// Operand/result bundle for the registered magnitude comparator.
//
// Signals:
//   in_valid   - operand pair A/B valid this cycle (master -> slave)
//   signed_cmp - 0 = unsigned, 1 = two's-complement compare (master -> slave)
//   A, B       - WIDTH-bit operands (master -> slave)
//   Y          - registered relation vector {EQ,NE,GT,LT,GE,LE} (slave -> master)
//   out_valid  - Y was updated from a valid pair this cycle (slave -> master)
//
// Modports:
//   master - the operand producer / result consumer
//   slave  - the comparator itself
// -----------------------------------------------------------------------------
interface comparator_2bit_if #(
    parameter int WIDTH = 2
);
    logic             in_valid;
    logic             signed_cmp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [5:0]       Y;
    logic             out_valid;

    modport master (
        output in_valid,
        output signed_cmp,
        output A,
        output B,
        input  Y,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  signed_cmp,
        input  A,
        input  B,
        output Y,
        output out_valid
    );
endinterface

// File: rtl/comparator_2bit.sv
// -----------------------------------------------------------------------------
// comparator_2bit
// Registered magnitude comparator. Compares two WIDTH-bit operands either as
// unsigned or as two's-complement values and registers the relation vector
// Y = {EQ, NE, GT, LT, GE, LE} one clock after a valid operand pair.
// When no valid pair is presented, Y holds and out_valid drops.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; clears Y and out_valid
//   bus  - comparator_2bit_if.slave (in_valid, signed_cmp, A, B -> Y, out_valid)
//
// WIDTH must be >= 1 and must match the WIDTH of the connected interface.
// -----------------------------------------------------------------------------
module comparator_2bit #(
    parameter int WIDTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    comparator_2bit_if.slave  bus
);

    logic [WIDTH-1:0] a_cmp;
    logic [WIDTH-1:0] b_cmp;
    logic             eq;
    logic             gt;
    logic             lt;

    logic [5:0]       y_d;
    logic [5:0]       y_q;
    logic             out_valid_d;
    logic             out_valid_q;

    // Relation logic. Signed operands are mapped to offset-binary by inverting
    // the sign bit; that mapping preserves ordering, so one unsigned magnitude
    // compare serves both modes. Equality never depends on the mode.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // so no path leaves a signal unassigned and no latch is inferred.
        a_cmp       = bus.A;
        b_cmp       = bus.B;
        y_d         = y_q;
        out_valid_d = 1'b0;

        if (bus.signed_cmp) begin
            a_cmp[WIDTH-1] = ~bus.A[WIDTH-1];
            b_cmp[WIDTH-1] = ~bus.B[WIDTH-1];
        end

        eq = (bus.A == bus.B);
        gt = (a_cmp > b_cmp);
        lt = (a_cmp < b_cmp);

        if (bus.in_valid) begin
            y_d         = {eq, ~eq, gt, lt, gt | eq, lt | eq};
            out_valid_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together at the edge regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q         <= 6'b000000;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Outputs come straight from flops: no combinational input-to-output path.
    assign bus.Y         = y_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_comparator_2bit.sv
// -----------------------------------------------------------------------------
// tb_comparator_2bit
// Self-checking bench for comparator_2bit. Instantiates a WIDTH=2 and a
// WIDTH=4 comparator on a shared clock/reset. Expected relation vectors come
// from an integer reference model that evaluates the operands as numbers.
// -----------------------------------------------------------------------------
module tb_comparator_2bit;

    logic clk;
    logic rst;

    int compared   = 0;
    int mismatched = 0;

    logic [5:0] exp_y;   // last valid result expected from the WIDTH=2 DUT

    comparator_2bit_if #(.WIDTH(2)) bus2 ();
    comparator_2bit_if #(.WIDTH(4)) bus4 ();

    comparator_2bit #(.WIDTH(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    comparator_2bit #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, got running, required finished");
        $fatal(1, "watchdog expired");
    end

    // Reference: interpret operands as integers, then apply the relations.
    function automatic logic [5:0] ref_y(input int w, input int a, input int b, input bit sgn);
        int av;
        int bv;
        av = a;
        bv = b;
        if (sgn) begin
            if (av >= (1 << (w - 1))) av = av - (1 << w);
            if (bv >= (1 << (w - 1))) bv = bv - (1 << w);
        end
        return {av == bv, av != bv, av > bv, av < bv, av >= bv, av <= bv};
    endfunction

    // Advance one active edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus2.in_valid   = 1'b0;
        bus2.signed_cmp = 1'bx;
        bus2.A          = 2'bxx;
        bus2.B          = 2'bxx;
        bus4.in_valid   = 1'b0;
        bus4.signed_cmp = 1'b0;
        bus4.A          = '0;
        bus4.B          = '0;
        #2;
        compared++;
        if (bus2.Y !== 6'b000000 || bus2.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_async: got Y=%b ov=%b, required Y=000000 ov=0", bus2.Y, bus2.out_valid);
        end
        @(negedge clk);
        compared++;
        if (bus2.Y !== 6'b000000 || bus2.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_hold: got Y=%b ov=%b, required Y=000000 ov=0", bus2.Y, bus2.out_valid);
        end
        // X inputs with in_valid low, then release: outputs must stay clean.
        #1 rst = 1'b0;
        step();
        compared++;
        if (bus2.Y !== 6'b000000 || bus2.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_no_x: got Y=%b ov=%b, required Y=000000 ov=0", bus2.Y, bus2.out_valid);
        end
        bus2.in_valid   = 1'b1;
        bus2.signed_cmp = 1'b0;
        bus2.A          = 2'b01;
        bus2.B          = 2'b01;
        step();
        compared++;
        if (bus2.Y !== 6'b100011 || bus2.out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_first_capture: got Y=%b ov=%b, required Y=100011 ov=1", bus2.Y, bus2.out_valid);
        end
        exp_y = 6'b100011;
    endtask

    task automatic test_unsigned_sweep();
        logic [1:0] a;
        logic [1:0] b;
        logic [5:0] e;
        for (int i = 0; i < 16; i++) begin
            a = 2'(i >> 2);
            b = 2'(i);
            bus2.in_valid   = 1'b1;
            bus2.signed_cmp = 1'b0;
            bus2.A          = a;
            bus2.B          = b;
            step();
            e = ref_y(2, int'(a), int'(b), 1'b0);
            compared++;
            if (bus2.Y !== e || bus2.out_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL sweep A=%b B=%b: got Y=%b ov=%b, required Y=%b ov=1", a, b, bus2.Y, bus2.out_valid, e);
            end
            if (a == 2'b00 && b == 2'b11) begin
                compared++;
                if (bus2.Y !== 6'b010101) begin
                    mismatched++;
                    $display("FAIL sweep_00_11: got Y=%b, required Y=010101", bus2.Y);
                end
            end
            if (a == 2'b11 && b == 2'b00) begin
                compared++;
                if (bus2.Y !== 6'b011010) begin
                    mismatched++;
                    $display("FAIL sweep_11_00: got Y=%b, required Y=011010", bus2.Y);
                end
            end
            exp_y = e;
        end
    endtask

    task automatic test_signed();
        bus2.in_valid   = 1'b1;
        bus2.signed_cmp = 1'b1;
        bus2.A          = 2'b11;
        bus2.B          = 2'b01;
        step();
        compared++;
        if (bus2.Y !== 6'b010101 || bus2.out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL signed_m1_vs_p1: got Y=%b ov=%b, required Y=010101 ov=1", bus2.Y, bus2.out_valid);
        end
        bus2.signed_cmp = 1'b0;
        step();
        compared++;
        if (bus2.Y !== 6'b011010 || bus2.out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL unsigned_3_vs_1: got Y=%b ov=%b, required Y=011010 ov=1", bus2.Y, bus2.out_valid);
        end
        bus2.signed_cmp = 1'b1;
        bus2.A          = 2'b10;
        bus2.B          = 2'b10;
        step();
        compared++;
        if (bus2.Y !== 6'b100011) begin
            mismatched++;
            $display("FAIL signed_eq: got Y=%b, required Y=100011", bus2.Y);
        end
        exp_y = 6'b100011;
    endtask

    task automatic test_hold();
        bus2.in_valid   = 1'b1;
        bus2.signed_cmp = 1'b0;
        bus2.A          = 2'b10;
        bus2.B          = 2'b01;
        step();
        compared++;
        if (bus2.Y !== 6'b011010 || bus2.out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL hold_capture: got Y=%b ov=%b, required Y=011010 ov=1", bus2.Y, bus2.out_valid);
        end
        bus2.in_valid = 1'b0;
        bus2.A        = 2'b00;
        bus2.B        = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            compared++;
            if (bus2.Y !== 6'b011010 || bus2.out_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL hold_cycle%0d: got Y=%b ov=%b, required Y=011010 ov=0", i, bus2.Y, bus2.out_valid);
            end
        end
        exp_y = 6'b011010;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            bus2.in_valid   = 1'b1;
            bus2.signed_cmp = 1'b0;
            bus2.A          = 2'(i + 1);
            bus2.B          = 2'(i);
            step();
        end
        // Pulse reset between edges with a valid pair still presented.
        #2 rst = 1'b1;
        bus2.A = 2'b10;
        bus2.B = 2'b10;
        #1;
        compared++;
        if (bus2.Y !== 6'b000000 || bus2.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset_clear: got Y=%b ov=%b, required Y=000000 ov=0", bus2.Y, bus2.out_valid);
        end
        #1 rst = 1'b0;
        step();
        compared++;
        if (bus2.Y !== 6'b100011 || bus2.out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_reset_recover: got Y=%b ov=%b, required Y=100011 ov=1", bus2.Y, bus2.out_valid);
        end
        exp_y = 6'b100011;
    endtask

    task automatic test_random();
        bit         v;
        bit         s;
        logic [1:0] a;
        logic [1:0] b;
        for (int i = 0; i < 200; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            s = 1'($urandom);
            a = 2'($urandom);
            b = 2'($urandom);
            bus2.in_valid   = v;
            bus2.signed_cmp = s;
            bus2.A          = a;
            bus2.B          = b;
            step();
            if (v) exp_y = ref_y(2, int'(a), int'(b), s);
            compared++;
            if (bus2.Y !== exp_y || bus2.out_valid !== v) begin
                mismatched++;
                $display("FAIL random%0d v=%b s=%b A=%b B=%b: got Y=%b ov=%b, required Y=%b ov=%b",
                         i, v, s, a, b, bus2.Y, bus2.out_valid, exp_y, v);
            end
        end
    endtask

    task automatic test_width4();
        logic [3:0] a;
        logic [3:0] b;
        bit         s;
        logic [5:0] e;
        bus4.in_valid   = 1'b1;
        bus4.signed_cmp = 1'b1;
        bus4.A          = 4'b1000;
        bus4.B          = 4'b0111;
        step();
        compared++;
        if (bus4.Y !== 6'b010101 || bus4.out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL w4_signed_m8_vs_p7: got Y=%b ov=%b, required Y=010101 ov=1", bus4.Y, bus4.out_valid);
        end
        bus4.signed_cmp = 1'b0;
        step();
        compared++;
        if (bus4.Y !== 6'b011010 || bus4.out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL w4_unsigned_8_vs_7: got Y=%b ov=%b, required Y=011010 ov=1", bus4.Y, bus4.out_valid);
        end
        for (int i = 0; i < 60; i++) begin
            s = 1'($urandom);
            a = 4'($urandom);
            b = 4'($urandom);
            bus4.signed_cmp = s;
            bus4.A          = a;
            bus4.B          = b;
            step();
            e = ref_y(4, int'(a), int'(b), s);
            compared++;
            if (bus4.Y !== e || bus4.out_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL w4_random%0d s=%b A=%b B=%b: got Y=%b ov=%b, required Y=%b ov=1",
                         i, s, a, b, bus4.Y, bus4.out_valid, e);
            end
        end
        bus4.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unsigned_sweep();
        test_signed();
        test_hold();
        test_mid_reset();
        test_random();
        test_width4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/comparator_2bit.md
Name: comparator_2bit

Overview:
- Registered magnitude comparator for two WIDTH-bit operands A and B (default 2 bits).
- Produces a 6-bit one-hot-free relation vector Y: EQ, NE, GT, LT, GE, LE.
- Intended as a small datapath utility feeding control/decision logic; results appear one clock after a valid operand pair is presented.

Parameters:
- WIDTH, 2, operand width in bits (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operand pair A/B valid this cycle.
- signed_cmp  input  1  0 = unsigned compare, 1 = two's-complement signed compare; sampled with A/B.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Y  output  6  registered relation vector. Y[5]=EQ (A==B), Y[4]=NE (A!=B), Y[3]=GT (A>B), Y[2]=LT (A<B), Y[1]=GE (A>=B), Y[0]=LE (A<=B).
- out_valid  output  1  Y updated from a valid pair on this cycle.

Behaviour:
- Reset: on rst high, asynchronously Y=6'b000000 and out_valid=0. Both hold while rst is high. First capture occurs on the first rising clk edge after rst deasserts.
- Latency: exactly 1 clock. A/B/signed_cmp are sampled at the rising edge where in_valid=1. Y and out_valid reflect that pair after the same edge.
- in_valid=0 at an edge: Y holds its previous value and out_valid=0.
- Back-to-back: in_valid high on consecutive edges gives a new result every cycle. No bubbles and no backpressure.
- Unsigned mode (signed_cmp=0): operands are treated as 0..2^WIDTH-1.
- Signed mode (signed_cmp=1): the MSB is the sign bit, giving the range -2^(WIDTH-1)..2^(WIDTH-1)-1. For WIDTH=2, 2'b10=-2 and 2'b11=-1.
- Consistency invariants on every valid result:
  - EQ = ~NE.
  - Exactly one of GT/LT/EQ is set.
  - GE = GT|EQ.
  - LE = LT|EQ.
  - Y is never all-zero after a valid capture.
- Equality is independent of signed_cmp.
- rst asserted mid-stream: the result in flight is discarded and outputs are cleared immediately, with no dependence on clk.
- No X propagation on outputs after reset, regardless of input X before the first valid.
- Logic is purely synchronous apart from the async reset. No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst with clk idle -> Y=000000 and out_valid=0 immediately. Deassert, apply in_valid=1, A=2'b01, B=2'b01, unsigned -> next edge Y=100011, out_valid=1.
- Exhaustive unsigned sweep of all 16 A/B pairs, in_valid held high, back-to-back. Each result lands one cycle after its inputs and matches the invariants:
  - A=00, B=11 -> Y=010101 (NE, LT, LE).
  - A=11, B=00 -> Y=011010 (NE, GT, GE).
- Signed mode: A=2'b11 (-1), B=2'b01 (+1), signed_cmp=1 -> Y=010101 (LT). The same operands with signed_cmp=0 -> Y=011010 (GT).
- Hold: a valid capture of A=10, B=01 unsigned (Y=011010), then in_valid=0 with A/B changed to 00/11 for 3 cycles -> Y stays 011010, out_valid=0.
- Mid-stream reset: stream valid pairs, pulse rst between edges -> Y=000000 and out_valid=0 asynchronously. After release, the next valid pair A=10, B=10 -> Y=100011.
- WIDTH=4 build, signed: A=4'b1000 (-8), B=4'b0111 (+7) -> Y=010101. Unsigned, same operands -> Y=011010.
